data_mem_ctrl: RTL

//  Sequencer between the CPU load/store stage and the word-wide data memory (data_mem).

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/data_mem_ctrl_byte_lane_unit.sv | 37 +++
 rtl/data_mem_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: MIPS load/store opcodes, controller state type and opcode class helpers.
package mips_mem_pkg;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} mem_ctrl_state_t;
  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
  endfunction
  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction
endpackage

// File: rtl/data_mem_ctrl_byte_lane_unit.sv
// byte_lane_unit: big-endian lane extraction/extension for loads and SB/SH merge word.
// LWL/LWR merge logic exists only when DATA_MEM_CTRL_LWLR_EN is defined.
module byte_lane_unit
  import mips_mem_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  input  logic [31:0] rt_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] lane_m;
  logic [31:0] lane_d;
  always_comb begin
    sh     = {offset_i, 3'b000};
    b      = 8'(word_i >> (5'd24 - sh));
    h      = offset_i[1] ? word_i[15:0] : word_i[31:16];
    lane_m = (opcode_i == OP_SH) ? (offset_i[1] ? 32'h0000FFFF : 32'hFFFF0000) : (32'hFF000000 >> sh);
    lane_d = (opcode_i == OP_SH) ? {2{rt_i[15:0]}} : {4{rt_i[7:0]}};
    store_o = (word_i & ~lane_m) | (lane_d & lane_m);
    case (opcode_i)
      OP_LB:   load_o = {{24{b[7]}}, b};
      OP_LBU:  load_o = {24'h0, b};
      OP_LH:   load_o = {{16{h[15]}}, h};
      OP_LHU:  load_o = {16'h0, h};
`ifdef DATA_MEM_CTRL_LWLR_EN
      OP_LWL:  load_o = (word_i << sh) | (rt_i & ~(32'hFFFFFFFF << sh));
      OP_LWR:  load_o = (word_i >> (5'd24 - sh)) | (rt_i & ~(32'hFFFFFFFF >> (5'd24 - sh)));
`endif
      default: load_o = word_i;
    endcase
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: one-at-a-time load/store sequencer to word-wide data memory with RMW byte/half stores.
// DATA_MEM_CTRL_LWLR_EN enables LWL/LWR; otherwise those opcodes are rejected as illegal.
module data_mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  mem_ctrl_state_t state_q;
  logic [5:0]  op_q;
  logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
  logic        resp_valid_q, resp_err_q;
  logic        legal, misalign, out_of_range, req_err, sub_store;
  logic [31:0] load_data, store_word;
`ifdef DATA_MEM_CTRL_LWLR_EN
  assign legal = is_load(req_opcode) || is_store(req_opcode);
`else
  assign legal = (is_load(req_opcode) && req_opcode != OP_LWL && req_opcode != OP_LWR) || is_store(req_opcode);
`endif
  assign misalign = ((req_opcode == OP_LH || req_opcode == OP_LHU || req_opcode == OP_SH) && req_address[0]) ||
                    ((req_opcode == OP_LW || req_opcode == OP_SW) && req_address[1:0] != 2'b00);
  assign out_of_range = {2'b00, req_address[31:2]} >= 32'(MEM_WORDS);
  assign req_err      = !legal || misalign || out_of_range;
  assign sub_store    = op_q == OP_SB || op_q == OP_SH;
  byte_lane_unit u_lane (
    .opcode_i (op_q),
    .offset_i (addr_q[1:0]),
    .word_i   (mem_rdata),
    .rt_i     (wdata_q),
    .load_o   (load_data),
    .store_o  (store_word)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req_valid) begin
          op_q         <= req_opcode;
          addr_q       <= req_address;
          wdata_q      <= req_wdata;
          resp_err_q   <= req_err;
          resp_valid_q <= req_err;
          state_q      <= req_err ? S_RESP : S_ACCESS;
        end
        S_ACCESS: begin
          if (is_load(op_q)) rdata_q <= load_data;
          merge_q      <= store_word;
          resp_valid_q <= !sub_store;
          state_q      <= sub_store ? S_WRITE : S_RESP;
        end
        S_WRITE: begin
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  // memory strobes come straight from state so a reset edge suppresses them immediately
  assign req_ready   = state_q == S_IDLE;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = rdata_q;
  assign mem_address = {addr_q[31:2], 2'b00};
  assign mem_read    = !reset && state_q == S_ACCESS;
  assign mem_write   = !reset && ((state_q == S_ACCESS && op_q == OP_SW) || state_q == S_WRITE);
  assign mem_wdata   = state_q == S_WRITE ? merge_q : wdata_q;
endmodule
